// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int ADDR_W_DEF = 8;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [XLEN_DEF-1:0]   instr;
      logic [ADDR_W_DEF-1:0] next_pc;
   } fetch_entry_t;

   typedef enum logic {
      CTL_RUN   = 1'b0,
      CTL_FLUSH = 1'b1
   } ctl_state_t;

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && (depth <= 16);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head word is read straight from the storage array.
module fetch_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, IRAM request credit, in-flight tracking, redirect flush.
//   state     | meaning
//   CTL_RUN   | normal fetch and delivery
//   CTL_FLUSH | cycle after a redirect edge; queue and in-flight fetch already discarded
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int              XLEN     = XLEN_DEF,
   parameter  int              ADDR_W   = ADDR_W_DEF,
   parameter  int              DEPTH    = 4,
   parameter  logic [ADDR_W-1:0] RESET_PC = '0,
   localparam int              CW       = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              clear,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic [XLEN-1:0]   imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [XLEN-1:0]   out_instr,
   output logic [ADDR_W-1:0] out_next_pc,
   output logic [CW-1:0]     count
);

   localparam int  EW          = 2 * ADDR_W + XLEN;
   localparam bit  DEPTH_LEGAL = depth_ok(DEPTH);

   ctl_state_t        state_q;
   ctl_state_t        state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic              inflight_q;
   logic              armed_q;
   logic              push;
   logic              pop;
   logic              credit_ok;
   logic [CW:0]       used;
   logic [EW-1:0]     fifo_wdata;
   logic [EW-1:0]     fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;

   // Credit counts the in-flight word; a same-cycle pop is deliberately not credited.
   assign used       = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign credit_ok  = (used < (CW + 1)'(DEPTH));
   assign imem_addr  = pc_q;
   assign fifo_wdata = {inflight_pc_q, imem_rdata, inflight_pc_q + ADDR_W'(1)};

   assign out_pc      = fifo_rdata[ADDR_W + XLEN +: ADDR_W];
   assign out_instr   = fifo_rdata[ADDR_W +: XLEN];
   assign out_next_pc = fifo_rdata[0 +: ADDR_W];

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state_q <= CTL_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = CTL_RUN;
      imem_req  = 1'b0;
      out_valid = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      if (redirect_valid) begin
         state_d = CTL_FLUSH;
      end else begin
         imem_req  = armed_q && credit_ok;
         out_valid = !fifo_empty;
         push      = inflight_q;
         pop       = !fifo_empty && out_ready;
      end
   end

   // armed_q holds off the first request until one edge after reset release.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         pc_q          <= RESET_PC;
         inflight_pc_q <= RESET_PC;
         inflight_q    <= 1'b0;
         armed_q       <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         if (redirect_valid) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
         end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
               pc_q          <= pc_q + ADDR_W'(1);
               inflight_pc_q <= pc_q;
            end
         end
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .clear (clear),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (pop),
      .flush (redirect_valid),
      .rdata (fifo_rdata),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   a_depth_legal: assert property (@(posedge clock) DEPTH_LEGAL);
   a_no_overflow: assert property (@(posedge clock) disable iff (!clear) !(push && fifo_full));
   a_flush_kills: assert property (@(posedge clock) disable iff (!clear)
                                   (state_q == CTL_FLUSH) |-> !inflight_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: issued fetches are queued as expected entries and checked on delivery.
module tb_fetch_queue;
   import fetch_pkg::*;

   logic        clock = 1'b0;
   logic        clear;
   logic [7:0]  imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_pc;
   logic [31:0] out_instr;
   logic [7:0]  out_next_pc;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   fetch_entry_t exp_q[$];

   fetch_queue dut (
      .clock          (clock),
      .clear          (clear),
      .imem_addr      (imem_addr),
      .imem_req       (imem_req),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_next_pc    (out_next_pc),
      .count          (count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] iram(input logic [7:0] a);
      return 32'h1000 + {24'h0, a};
   endfunction

   always @(posedge clock) begin
      if (imem_req) imem_rdata <= iram(imem_addr);
      else          imem_rdata <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      fetch_entry_t e;
      if (!clear) begin
         exp_q.delete();
      end else begin
         if (redirect_valid) begin
            chk("redir_out_valid", {31'h0, out_valid}, 32'h0);
            chk("redir_imem_req", {31'h0, imem_req}, 32'h0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", {24'h0, out_pc}, {24'h0, e.pc});
               chk("sb_instr", out_instr, e.instr);
               chk("sb_next_pc", {24'h0, out_next_pc}, {24'h0, e.next_pc});
            end
         end
         if (redirect_valid) exp_q.delete();
         if (imem_req)
            exp_q.push_back('{pc: imem_addr, instr: iram(imem_addr), next_pc: imem_addr + 8'd1});
      end
   end

   task automatic drive_step();
      @(posedge clock);
      #2;
   endtask

   initial begin
      bit found;
      clear          = 1'b0;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;

      // reset values and first-fetch latency
      repeat (3) @(negedge clock);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_count", {29'h0, count}, 32'h0);
      chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
      chk("rst_imem_addr", {24'h0, imem_addr}, 32'h0);
      #1 clear = 1'b1;
      #1 chk("req_at_release", {31'h0, imem_req}, 32'h0);
      @(negedge clock);
      chk("req_rise", {31'h0, imem_req}, 32'h1);
      chk("first_addr", {24'h0, imem_addr}, 32'h0);
      @(negedge clock);
      chk("lat_n1_valid", {31'h0, out_valid}, 32'h0);
      @(negedge clock);
      chk("lat_n2_valid", {31'h0, out_valid}, 32'h1);
      chk("lat_n2_pc", {24'h0, out_pc}, 32'h0);
      chk("lat_n2_instr", out_instr, 32'h1000);
      repeat (6) begin
         @(negedge clock);
         chk("stream_valid", {31'h0, out_valid}, 32'h1);
      end

      // backpressure from reset
      drive_step();
      clear     = 1'b0;
      out_ready = 1'b0;
      @(negedge clock);
      #1 clear = 1'b1;
      repeat (10) @(negedge clock);
      chk("bp_count", {29'h0, count}, 32'h4);
      chk("bp_req", {31'h0, imem_req}, 32'h0);
      chk("bp_addr", {24'h0, imem_addr}, 32'h4);
      chk("bp_head_pc", {24'h0, out_pc}, 32'h0);
      chk("bp_valid", {31'h0, out_valid}, 32'h1);
      drive_step();
      out_ready = 1'b1;
      repeat (10) @(negedge clock);

      // redirect on a full queue
      drive_step();
      out_ready = 1'b0;
      repeat (8) @(negedge clock);
      chk("full_count", {29'h0, count}, 32'h4);
      drive_step();
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      @(negedge clock);
      chk("rdf_valid", {31'h0, out_valid}, 32'h0);
      chk("rdf_req", {31'h0, imem_req}, 32'h0);
      drive_step();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      @(negedge clock);
      chk("rdf_count", {29'h0, count}, 32'h0);
      chk("rdf_addr", {24'h0, imem_addr}, 32'h40);
      chk("rdf_req_after", {31'h0, imem_req}, 32'h1);
      @(negedge clock);
      @(negedge clock);
      chk("rdf_first_valid", {31'h0, out_valid}, 32'h1);
      chk("rdf_first_pc", {24'h0, out_pc}, 32'h40);

      // redirect while a response is returning
      repeat (4) @(negedge clock);
      chk("pre_rd_req", {31'h0, imem_req}, 32'h1);
      drive_step();
      redirect_valid = 1'b1;
      redirect_pc    = 8'h80;
      drive_step();
      redirect_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("rdi_first_pc", {24'h0, out_pc}, 32'h80);
      chk("rdi_first_valid", {31'h0, out_valid}, 32'h1);

      // back-to-back redirects, PC wrap
      drive_step();
      redirect_valid = 1'b1;
      redirect_pc    = 8'h10;
      drive_step();
      redirect_pc    = 8'hFE;
      drive_step();
      redirect_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("wrap0_pc", {24'h0, out_pc}, 32'hFE);
      chk("wrap0_npc", {24'h0, out_next_pc}, 32'hFF);
      @(negedge clock);
      chk("wrap1_pc", {24'h0, out_pc}, 32'hFF);
      chk("wrap1_npc", {24'h0, out_next_pc}, 32'h00);
      @(negedge clock);
      chk("wrap2_pc", {24'h0, out_pc}, 32'h00);
      chk("wrap2_npc", {24'h0, out_next_pc}, 32'h01);

      // random stall / redirect mix, checked by the scoreboard
      for (int i = 0; i < 200; i++) begin
         drive_step();
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = 8'($urandom_range(0, 255));
      end
      drive_step();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      repeat (10) @(negedge clock);

      // asynchronous clear with three entries buffered
      drive_step();
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h20;
      drive_step();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (count == 3'd3) found = 1'b1;
      end
      chk("wait_count3", {31'h0, found}, 32'h1);
      #2 clear = 1'b0;
      #1;
      chk("aclr_valid", {31'h0, out_valid}, 32'h0);
      chk("aclr_count", {29'h0, count}, 32'h0);
      chk("aclr_req", {31'h0, imem_req}, 32'h0);
      chk("aclr_addr", {24'h0, imem_addr}, 32'h0);
      @(negedge clock);
      #1;
      clear     = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      chk("rel_req", {31'h0, imem_req}, 32'h1);
      chk("rel_addr", {24'h0, imem_addr}, 32'h0);
      @(negedge clock);
      @(negedge clock);
      chk("rel_first_valid", {31'h0, out_valid}, 32'h1);
      chk("rel_first_pc", {24'h0, out_pc}, 32'h0);
      repeat (5) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined RISC-V core; it replaces the bare PC register + IF_ID pair.
- Drives the synchronous instruction RAM (1-cycle read latency) and buffers up to DEPTH fetched instructions with their PC and PC+1.
- Presents buffered instructions to decode over a valid/ready handshake, so a decode stall no longer freezes the PC.
- Accepts a redirect (branch/jump resolved in MEM) that flushes all buffered and in-flight fetches.

Parameters:
- XLEN, 32, instruction width in bits.
- ADDR_W, 8, word-address width of the PC and IRAM (PC counts words, increments by 1).
- DEPTH, 4, queue entries; legal 2..16; full throughput requires DEPTH >= 3.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  reset; asynchronous assert, active-low.
- imem_addr  out  ADDR_W  IRAM word address; equals the internal PC.
- imem_req  out  1  a fetch is issued at imem_addr this cycle.
- imem_rdata  in  XLEN  IRAM data; valid in the cycle after imem_req.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  ADDR_W  PC of the head instruction.
- out_instr  out  XLEN  head instruction.
- out_next_pc  out  ADDR_W  out_pc+1 mod 2^ADDR_W, used for the jal/jalr link value.
- count  out  $clog2(DEPTH+1)  entries currently buffered.

Behaviour:
- Reset (clear=0, asynchronous):
  - PC=RESET_PC; queue empty; in-flight flag cleared.
  - out_valid=0, count=0, imem_req=0, imem_addr=RESET_PC.
  - Deasserting clear mid-stream discards everything; the first fetch after release is RESET_PC.
- Credit:
  - imem_req = !redirect_valid && (count + inflight) < DEPTH.
  - Same-cycle pops do not add credit.
- Issue: on an edge with imem_req=1:
  - PC <= PC+1, wrapping modulo 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8).
  - inflight <= 1; inflight_pc <= PC.
- Response:
  - In the cycle after issue, {inflight_pc, imem_rdata, inflight_pc+1} is pushed at the next edge unless redirect_valid=1 in that cycle.
  - inflight clears unless a new issue occurs on the same edge.
- Latency: issue at cycle N -> out_valid at cycle N+2 when the queue was empty. No bypass from imem_rdata to the outputs.
- Pop: on an edge with out_valid && out_ready, the head advances.
  - Simultaneous push and pop leaves count unchanged.
  - Push into a full queue cannot occur by construction; an assertion flags it.
- Head outputs are registered queue contents. They hold stable while out_valid=1 and out_ready=0.
- Redirect (highest priority):
  - In the cycle redirect_valid=1: out_valid is forced 0, so no pop occurs, and imem_req=0.
  - On the edge: queue cleared, count=0, in-flight fetch killed, PC <= redirect_pc.
  - The first fetch of redirect_pc is issued in the next cycle.
  - Back-to-back redirects: the last one wins.
- Ordering: entries leave in exact fetch order; no duplicates or gaps between redirects.
- Control state (one-hot or encoded, implementer's choice):
  - RUN: normal operation.
  - FLUSH: one cycle, entered on redirect_valid; returns to RUN unless redirect_valid stays high.
  - Reset enters RUN.

Decomposition:
- Shared package fetch_pkg holds:
  - default XLEN/ADDR_W constants;
  - the entry struct {pc, instr, next_pc};
  - the DEPTH legality check function.
- One sub-module, fetch_fifo: a parametrised synchronous FIFO (width, depth) with push, pop, flush, count, full and empty.
- fetch_queue owns the PC, credit logic, in-flight tracking and redirect control.

Test Plan:
- Reset release, out_ready=1, IRAM[k]=0x1000+k -> imem_req rises the cycle after release; first out_valid 2 cycles after the first request with out_pc=0 and out_instr=0x1000; then one instruction per cycle, out_next_pc=out_pc+1.
- Hold out_ready=0 from start -> count saturates at 4; imem_req drops once count+inflight=4; PC stops at 4; head stays at pc 0 until out_ready=1, then 0,1,2,3,4... are delivered in order with no loss.
- Full queue, redirect_valid=1 with redirect_pc=0x40 -> the same cycle shows out_valid=0 and imem_req=0; next cycle count=0 and imem_addr=0x40; the first delivered out_pc is 0x40; no pre-redirect entry ever appears.
- Redirect in the cycle a response returns (inflight=1) -> the returning word is dropped; the next delivered out_pc equals redirect_pc.
- redirect_pc=0xFE, ADDR_W=8 -> the delivered sequence is 0xFE, 0xFF, 0x00 with out_next_pc 0xFF, 0x00, 0x01.
- clear pulsed low mid-stream with 3 entries buffered -> outputs go to reset values immediately (asynchronously); after release fetch restarts at RESET_PC.
